dino_sprite_render: RTL and testbench
=====================================

Name: dino_sprite_render

Overview:
- Pixel-stage renderer directly downstream of the dino jump/location block.
- Consumes its 4-bit vertical `position` plus the VGA timing generator's pixel stream (x, y, valid, frame_start), and produces a 12-bit RGB pixel.
- Draws a 16x16 scaled dino sprite over a flat background, with a two-pose run animation on the ground.
- Fixed 2-cycle pipeline, so the VGA sync path delays hsync/vsync by 2 to match.

Parameters:
- DINO_X, 64: left screen column of sprite.
- GROUND_Y, 400: first screen row below the sprite's feet at position 0.
- SCALE, 2: pixel replication factor; legal values 1, 2, 4 only.
- STEP, 8: screen rows per `position` unit.
- ANIM_FRAMES, 6: frames per run-pose toggle.

Ports:
- clk, in, 1: pixel clock.
- reset, in, 1: synchronous, active-high.
- pix_valid, in, 1: pix_x/pix_y are an active-area pixel this cycle.
- pix_x, in, 10: pixel column.
- pix_y, in, 10: pixel row.
- frame_start, in, 1: one-cycle pulse in vertical blanking before the first active pixel.
- position, in, 4: dino height from the location block, 0 = on ground.
- rgb, out, 12: {R4,G4,B4} pixel.
- rgb_valid, out, 1: pix_valid delayed 2 cycles.
- in_sprite, out, 1: the output pixel lies inside the sprite box (debug/collision).

Behaviour:
- Reset: position_q=0, anim_cnt=0, leg_sel=0, all pipeline valid regs 0; outputs rgb=0, rgb_valid=0, in_sprite=0 from the next edge.
- Frame latch:
  - On a clk edge with frame_start=1, position_q<=position.
  - position_q changes only here, so there is no mid-frame tearing.
  - Pixels presented in the frame_start cycle use the old position_q.
- Animation, on each frame_start:
  - If the newly latched position is 0: anim_cnt increments; at ANIM_FRAMES-1 it clears to 0 and leg_sel toggles.
  - Otherwise: anim_cnt<=0, leg_sel<=0.
- Sprite select:
  - sprite_id = 0 (jump pose) if position_q != 0.
  - Else sprite_id = 1 + leg_sel.
  - Encoding 3 is unused and renders as all-zero rows.
- Geometry:
  - top_y = GROUND_Y - 16*SCALE - position_q*STEP, computed in 11-bit unsigned. Defaults give 368 down to 248; no underflow is possible with legal parameters.
  - hit = DINO_X <= pix_x < DINO_X+16*SCALE and top_y <= pix_y < top_y+16*SCALE.
  - col = (pix_x-DINO_X)>>log2(SCALE); row = (pix_y-top_y)>>log2(SCALE); each 4 bits.
- Stage 1 (edge 1): register v1=pix_valid, hit1, row1, col1, sprite_id1.
- Stage 2 (edge 2):
  - ROM row = rom(sprite_id1,row1); bit = row[15-col1], where bit 15 is the leftmost column.
  - rgb <= !v1 ? 0 : (hit1 & bit) ? FG_COLOR : BG_COLOR.
  - rgb_valid <= v1; in_sprite <= v1 & hit1.
- Latency is exactly 2 cycles, full throughput, no back-pressure.
- Boundaries:
  - pix_x = DINO_X+16*SCALE is not a hit.
  - position=15 is legal and gives the highest sprite.
  - Reset mid-frame flushes the pipeline; the outputs are 0 until valid pixels propagate again 2 cycles after reset deasserts.
  - pix_valid=0 forces rgb=0 regardless of hit.
  - frame_start coincident with pix_valid is permitted and does not corrupt that pixel.

Optional Feature:
- Macro: DINO_SHADOW_EN.
- Defined: pixels with pix_y in {GROUND_Y, GROUND_Y+1}, DINO_X <= pix_x < DINO_X+16*SCALE, and position_q != 0 render SHADOW_COLOR.
  - The shadow is drawn only when no sprite bit is set there.
  - in_sprite is unaffected.
- Undefined: no shadow logic; those pixels render BG_COLOR.

Decomposition:
- dino_pkg holds:
  - FG_COLOR=12'h555, BG_COLOR=12'hFFF, SHADOW_COLOR=12'hAAA.
  - SPRITE_W=SPRITE_H=16.
  - Sprite IDs SPR_JUMP=0, SPR_RUN_A=1, SPR_RUN_B=2.
- Sub-module dino_sprite_rom: combinational case ROM, inputs sprite_id[1:0] and row[3:0], output 16-bit row bitmap.
  - Row 0 of every sprite has bit 15 set, for testability.

Test Plan:
- Reset, frame_start with position=0, then pixel (64,368) -> 2 cycles later rgb_valid=1, in_sprite=1, rgb=12'h555. Pixel (96,368) -> in_sprite=0, rgb=12'hFFF.
- Latch position=3 at frame_start -> top_y=344; pixel (64,344) gives in_sprite=1; pixel (64,368) hits row 12.
- Change position from 3 to 7 mid-frame without frame_start -> rendering stays at top_y=344 until the next frame_start, then moves to 312.
- 6 frame_starts with position=0 -> leg_sel toggles once (SPR_RUN_B). Then position=2 at frame_start -> sprite_id=0, anim_cnt=0.
- Stream pixels, assert reset for 1 cycle mid-line -> rgb_valid=0 and rgb=0 from the next edge; valid returns 2 cycles after pix_valid resumes.
- With DINO_SHADOW_EN and position=4, pixel (70,400) -> rgb=12'hAAA, in_sprite=0. Without the macro -> rgb=12'hFFF.

Source files
------------

// File: rtl/dino_pkg.sv
// Shared constants and types for the dino sprite renderer.
package dino_pkg;

   // Output colours, {R4,G4,B4}
   localparam logic [11:0] FG_COLOR     = 12'h555;
   localparam logic [11:0] BG_COLOR     = 12'hFFF;
   localparam logic [11:0] SHADOW_COLOR = 12'hAAA;

   // Unscaled sprite size in bitmap pixels
   localparam int unsigned SPRITE_W = 16;
   localparam int unsigned SPRITE_H = 16;

   // Sprite selector; SPR_NONE has no bitmap and renders as all-zero rows
   typedef enum logic [1:0] {
      SPR_JUMP  = 2'd0,
      SPR_RUN_A = 2'd1,
      SPR_RUN_B = 2'd2,
      SPR_NONE  = 2'd3
   } sprite_id_e;

   // Replication factor to shift amount; only 1, 2 and 4 are legal scales
   function automatic int unsigned scale_shift(input int unsigned scale);
      if (scale >= 4) begin
         return 2;
      end else if (scale >= 2) begin
         return 1;
      end else begin
         return 0;
      end
   endfunction

endpackage

// File: rtl/dino_sprite_rom.sv
// Combinational bitmap ROM for the dino sprites. Bit 15 is the leftmost column.
// Rows 0-11 (head and body) are shared; rows 12-15 carry the pose-specific legs.
// Row 0 of every real sprite has bit 15 set so the top-left corner is observable.
module dino_sprite_rom
   import dino_pkg::*;
(
   input  sprite_id_e  sprite_id,
   input  logic [3:0]  row,
   output logic [15:0] row_bits
);

   // Row lookup; unused sprite id yields an empty row
   always_comb begin
      row_bits = '0;
      if (sprite_id != SPR_NONE) begin
         unique case (row)
            4'd0:  row_bits = 16'h8FF0;
            4'd1:  row_bits = 16'h0DF8;
            4'd2:  row_bits = 16'h0FF8;
            4'd3:  row_bits = 16'h0FC0;
            4'd4:  row_bits = 16'h0FF0;
            4'd5:  row_bits = 16'h8F80;
            4'd6:  row_bits = 16'hCFE0;
            4'd7:  row_bits = 16'hFF80;
            4'd8:  row_bits = 16'h7F80;
            4'd9:  row_bits = 16'h3F00;
            4'd10: row_bits = 16'h1F00;
            4'd11: row_bits = 16'h1E00;
            4'd12: row_bits = (sprite_id == SPR_JUMP)  ? 16'h1B00 :
                              (sprite_id == SPR_RUN_A) ? 16'h1900 : 16'h1300;
            4'd13: row_bits = 16'h1100;
            4'd14: row_bits = (sprite_id == SPR_JUMP)  ? 16'h1100 :
                              (sprite_id == SPR_RUN_A) ? 16'h1800 : 16'h0100;
            4'd15: row_bits = (sprite_id == SPR_JUMP)  ? 16'h1980 :
                              (sprite_id == SPR_RUN_A) ? 16'h0000 : 16'h0180;
            default: row_bits = '0;
         endcase
      end
   end

endmodule

// File: rtl/dino_sprite_render.sv
// Two-stage pixel renderer for the dino sprite over a flat background.
// Stage 1 resolves sprite geometry, stage 2 does the ROM lookup and colouring.
// Optional ground shadow under a jumping dino: define DINO_SHADOW_EN.
module dino_sprite_render
   import dino_pkg::*;
#(
   parameter int unsigned DINO_X      = 64,
   parameter int unsigned GROUND_Y    = 400,
   parameter int unsigned SCALE       = 2,
   parameter int unsigned STEP        = 8,
   parameter int unsigned ANIM_FRAMES = 6
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pix_valid,
   input  logic [9:0]  pix_x,
   input  logic [9:0]  pix_y,
   input  logic        frame_start,
   input  logic [3:0]  position,
   output logic [11:0] rgb,
   output logic        rgb_valid,
   output logic        in_sprite
);

   localparam int unsigned SHIFT = scale_shift(SCALE);
   localparam int unsigned SPAN  = SPRITE_W * SCALE;
   localparam int unsigned CNT_W = (ANIM_FRAMES > 2) ? $clog2(ANIM_FRAMES) : 1;

   localparam logic [10:0]      X_LO      = 11'(DINO_X);
   localparam logic [10:0]      X_HI      = 11'(DINO_X + SPAN);
   localparam logic [10:0]      TOP_GND   = 11'(GROUND_Y - SPRITE_H * SCALE);
   localparam logic [10:0]      SPAN_W    = 11'(SPAN);
   localparam logic [10:0]      STEP_W    = 11'(STEP);
   localparam logic [CNT_W-1:0] ANIM_LAST = CNT_W'(ANIM_FRAMES - 1);

   // Per-frame state
   logic [3:0]       position_q;
   logic [CNT_W-1:0] anim_cnt_q;
   logic             leg_sel_q;

   // Stage 1 signals
   logic [10:0] px, py, top_y, dx, dy;
   logic        hit_x, hit_y, hit;
   logic [3:0]  row, col;
   sprite_id_e  sprite_id;
   logic        v1_q, hit1_q;
   logic [3:0]  row1_q, col1_q;
   sprite_id_e  sprite_id1_q;

   // Stage 2 signals
   logic [15:0] rom_row;
   logic [3:0]  bit_idx;
   logic        sprite_bit;
   logic [11:0] rgb_d;
   logic [11:0] rgb_q;
   logic        rgb_valid_q, in_sprite_q;

`ifdef DINO_SHADOW_EN
   localparam logic [10:0] SH_Y0 = 11'(GROUND_Y);
   localparam logic [10:0] SH_Y1 = 11'(GROUND_Y + 1);
   logic shadow, shadow1_q;
`endif

   // Latch height and advance the run animation once per frame, so a frame never tears
   always_ff @(posedge clk) begin
      if (reset) begin
         position_q <= '0;
         anim_cnt_q <= '0;
         leg_sel_q  <= 1'b0;
      end else if (frame_start) begin
         position_q <= position;
         if (position == 4'd0) begin
            if (anim_cnt_q == ANIM_LAST) begin
               anim_cnt_q <= '0;
               leg_sel_q  <= ~leg_sel_q;
            end else begin
               anim_cnt_q <= anim_cnt_q + 1'b1;
            end
         end else begin
            anim_cnt_q <= '0;
            leg_sel_q  <= 1'b0;
         end
      end
   end

   // Sprite box geometry and bitmap coordinates for the incoming pixel
   always_comb begin
      px        = {1'b0, pix_x};
      py        = {1'b0, pix_y};
      top_y     = TOP_GND - (11'(position_q) * STEP_W);
      hit_x     = (px >= X_LO) && (px < X_HI);
      hit_y     = (py >= top_y) && (py < top_y + SPAN_W);
      hit       = hit_x && hit_y;
      dx        = px - X_LO;
      dy        = py - top_y;
      col       = 4'(dx >> SHIFT);
      row       = 4'(dy >> SHIFT);
      sprite_id = (position_q != 4'd0) ? SPR_JUMP : (leg_sel_q ? SPR_RUN_B : SPR_RUN_A);
`ifdef DINO_SHADOW_EN
      shadow    = ((py == SH_Y0) || (py == SH_Y1)) && hit_x && (position_q != 4'd0);
`endif
   end

   // Stage 1 register
   always_ff @(posedge clk) begin
      if (reset) begin
         v1_q         <= 1'b0;
         hit1_q       <= 1'b0;
         row1_q       <= '0;
         col1_q       <= '0;
         sprite_id1_q <= SPR_JUMP;
`ifdef DINO_SHADOW_EN
         shadow1_q    <= 1'b0;
`endif
      end else begin
         v1_q         <= pix_valid;
         hit1_q       <= hit;
         row1_q       <= row;
         col1_q       <= col;
         sprite_id1_q <= sprite_id;
`ifdef DINO_SHADOW_EN
         shadow1_q    <= shadow;
`endif
      end
   end

   dino_sprite_rom u_rom (
      .sprite_id (sprite_id1_q),
      .row       (row1_q),
      .row_bits  (rom_row)
   );

   // Pixel colour: sprite bit over optional shadow over background, blank when invalid
   always_comb begin
      bit_idx    = 4'd15 - col1_q;
      sprite_bit = rom_row[bit_idx];
      rgb_d      = BG_COLOR;
      if (!v1_q) begin
         rgb_d = 12'h000;
      end else if (hit1_q && sprite_bit) begin
         rgb_d = FG_COLOR;
`ifdef DINO_SHADOW_EN
      end else if (shadow1_q) begin
         rgb_d = SHADOW_COLOR;
`endif
      end
   end

   // Stage 2 register
   always_ff @(posedge clk) begin
      if (reset) begin
         rgb_q       <= '0;
         rgb_valid_q <= 1'b0;
         in_sprite_q <= 1'b0;
      end else begin
         rgb_q       <= rgb_d;
         rgb_valid_q <= v1_q;
         in_sprite_q <= v1_q & hit1_q;
      end
   end

   assign rgb       = rgb_q;
   assign rgb_valid = rgb_valid_q;
   assign in_sprite = in_sprite_q;

endmodule

// File: tb/tb_dino_sprite_render.sv
// Self-checking bench for dino_sprite_render: behavioural model compared every cycle,
// plus literal expectations for the directed scenarios. Honours DINO_SHADOW_EN.
module tb_dino_sprite_render;

   localparam int DINO_X      = 64;
   localparam int GROUND_Y    = 400;
   localparam int SCALE       = 2;
   localparam int STEP        = 8;
   localparam int ANIM_FRAMES = 6;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        pix_valid = 1'b0;
   logic [9:0]  pix_x = '0;
   logic [9:0]  pix_y = '0;
   logic        frame_start = 1'b0;
   logic [3:0]  position = '0;
   logic [11:0] rgb;
   logic        rgb_valid;
   logic        in_sprite;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [11:0] rgb;
      logic        vld;
      logic        ins;
   } exp_t;

   dino_sprite_render #(
      .DINO_X      (DINO_X),
      .GROUND_Y    (GROUND_Y),
      .SCALE       (SCALE),
      .STEP        (STEP),
      .ANIM_FRAMES (ANIM_FRAMES)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .pix_valid   (pix_valid),
      .pix_x       (pix_x),
      .pix_y       (pix_y),
      .frame_start (frame_start),
      .position    (position),
      .rgb         (rgb),
      .rgb_valid   (rgb_valid),
      .in_sprite   (in_sprite)
   );

   always #5 clk = ~clk;

   // Sprite bitmaps: index [pose][row], pose 0 jump, 1 run A, 2 run B
   logic [15:0] spr_tab [3][16];
   initial begin
      logic [15:0] body [12];
      body = '{16'h8FF0, 16'h0DF8, 16'h0FF8, 16'h0FC0, 16'h0FF0, 16'h8F80,
               16'hCFE0, 16'hFF80, 16'h7F80, 16'h3F00, 16'h1F00, 16'h1E00};
      for (int s = 0; s < 3; s++) begin
         for (int r = 0; r < 12; r++) spr_tab[s][r] = body[r];
         spr_tab[s][13] = 16'h1100;
      end
      spr_tab[0][12] = 16'h1B00; spr_tab[0][14] = 16'h1100; spr_tab[0][15] = 16'h1980;
      spr_tab[1][12] = 16'h1900; spr_tab[1][14] = 16'h1800; spr_tab[1][15] = 16'h0000;
      spr_tab[2][12] = 16'h1300; spr_tab[2][14] = 16'h0100; spr_tab[2][15] = 16'h0180;
   end

   // What the screen shows for one pixel given the latched height and leg pose
   function automatic exp_t model_pix(int x, int y, bit v, int pos, bit leg);
      exp_t e;
      int top, sid, r, c;
      bit hx, hit, on;
      e = '0;
      if (!v) return e;
      top = GROUND_Y - 16 * SCALE - pos * STEP;
      hx  = (x >= DINO_X) && (x < DINO_X + 16 * SCALE);
      hit = hx && (y >= top) && (y < top + 16 * SCALE);
      on  = 1'b0;
      if (hit) begin
         sid = (pos != 0) ? 0 : (leg ? 2 : 1);
         r   = (y - top) / SCALE;
         c   = (x - DINO_X) / SCALE;
         on  = spr_tab[sid][r][15 - c];
      end
      e.vld = 1'b1;
      e.ins = hit;
      e.rgb = on ? 12'h555 : 12'hFFF;
`ifdef DINO_SHADOW_EN
      if (!on && hx && pos != 0 && (y == GROUND_Y || y == GROUND_Y + 1)) e.rgb = 12'hAAA;
`endif
      return e;
   endfunction

   // Reference model: per-frame state plus a two-deep output delay
   int   m_pos = 0, m_cnt = 0;
   bit   m_leg = 1'b0;
   bit   started = 1'b0;
   exp_t e1 = '0, exp_out = '0;

   always @(posedge clk) begin
      if (reset) begin
         m_pos   <= 0;
         m_cnt   <= 0;
         m_leg   <= 1'b0;
         e1      <= '0;
         exp_out <= '0;
         started <= 1'b1;
      end else begin
         exp_out <= e1;
         e1      <= model_pix(int'(pix_x), int'(pix_y), pix_valid, m_pos, m_leg);
         if (frame_start) begin
            m_pos <= int'(position);
            if (position == 0) begin
               if (m_cnt + 1 == ANIM_FRAMES) begin
                  m_cnt <= 0;
                  m_leg <= !m_leg;
               end else begin
                  m_cnt <= m_cnt + 1;
               end
            end else begin
               m_cnt <= 0;
               m_leg <= 1'b0;
            end
         end
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (started) begin
         total += 3;
         if (rgb !== exp_out.rgb) begin
            bad++;
            $display("FAIL model_rgb t=%0t got=%h want=%h", $time, rgb, exp_out.rgb);
         end
         if (rgb_valid !== exp_out.vld) begin
            bad++;
            $display("FAIL model_valid t=%0t got=%b want=%b", $time, rgb_valid, exp_out.vld);
         end
         if (in_sprite !== exp_out.ins) begin
            bad++;
            $display("FAIL model_in_sprite t=%0t got=%b want=%b", $time, in_sprite, exp_out.ins);
         end
      end
   end

   task automatic check(input string name, input logic [11:0] got, input logic [11:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   task automatic frame(input int p);
      @(negedge clk);
      frame_start = 1'b1;
      position    = 4'(p);
      pix_valid   = 1'b0;
      @(negedge clk);
      frame_start = 1'b0;
   endtask

   // Present one pixel, then check the outputs two edges later
   task automatic probe(input string name, input int x, input int y,
                        input logic [11:0] want_rgb, input bit want_in);
      @(negedge clk);
      pix_x = 10'(x); pix_y = 10'(y); pix_valid = 1'b1;
      @(negedge clk);
      pix_valid = 1'b0;
      @(negedge clk);
      check({name, "_valid"}, {11'd0, rgb_valid}, 12'd1);
      check({name, "_rgb"}, rgb, want_rgb);
      check({name, "_in"}, {11'd0, in_sprite}, {11'd0, want_in});
   endtask

   initial begin
      logic [11:0] shadow_rgb;
`ifdef DINO_SHADOW_EN
      shadow_rgb = 12'hAAA;
`else
      shadow_rgb = 12'hFFF;
`endif
      repeat (3) @(negedge clk);
      check("reset_rgb", rgb, 12'h000);
      check("reset_valid", {11'd0, rgb_valid}, 12'd0);
      check("reset_in", {11'd0, in_sprite}, 12'd0);
      reset = 1'b0;

      // Ground pose, top-left corner and right edge just outside
      frame(0);
      probe("p0_corner", 64, 368, 12'h555, 1'b1);
      probe("p0_xedge", 96, 368, 12'hFFF, 1'b0);

      // Raised by 3
      frame(3);
      probe("p3_corner", 64, 344, 12'h555, 1'b1);
      probe("p3_row12", 64, 368, 12'hFFF, 1'b1);

      // Mid-frame height change is not visible until the next frame_start
      @(negedge clk);
      position = 4'd7;
      probe("p7_held", 64, 344, 12'h555, 1'b1);
      frame(7);
      probe("p7_corner", 64, 312, 12'h555, 1'b1);
      probe("p7_below", 64, 344, 12'hFFF, 1'b0);

      // Run animation: five ground frames keep pose A, the sixth swaps to pose B
      for (int i = 0; i < 5; i++) frame(0);
      probe("run_a_leg", 72, 392, 12'h555, 1'b1);
      frame(0);
      probe("run_b_leg", 72, 392, 12'hFFF, 1'b1);
      frame(2);
      probe("p2_corner", 64, 352, 12'h555, 1'b1);

      // Shadow region below a jumping dino
      frame(4);
      probe("shadow", 70, 400, shadow_rgb, 1'b0);

      // Invalid pixel over the sprite is blanked
      @(negedge clk);
      pix_x = 10'd64; pix_y = 10'd336; pix_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("novalid_rgb", rgb, 12'h000);
      check("novalid_in", {11'd0, in_sprite}, 12'd0);

      // frame_start alongside a valid pixel: that pixel still sees the old height
      @(negedge clk);
      frame_start = 1'b1; position = 4'd15;
      pix_x = 10'd64; pix_y = 10'd336; pix_valid = 1'b1;
      @(negedge clk);
      frame_start = 1'b0; pix_valid = 1'b0;
      @(negedge clk);
      check("fs_coincident_rgb", rgb, 12'h555);
      check("fs_coincident_in", {11'd0, in_sprite}, 12'd1);
      probe("p15_corner", 64, 248, 12'h555, 1'b1);
      probe("p15_above", 64, 247, 12'hFFF, 1'b0);
      probe("p15_lastcol", 95, 248, 12'hFFF, 1'b1);

      // Reset mid-line flushes the pipeline
      @(negedge clk);
      pix_x = 10'd64; pix_y = 10'd248; pix_valid = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midreset_valid0", {11'd0, rgb_valid}, 12'd0);
      check("midreset_rgb0", rgb, 12'h000);
      @(negedge clk);
      check("midreset_valid1", {11'd0, rgb_valid}, 12'd0);
      @(negedge clk);
      check("midreset_valid2", {11'd0, rgb_valid}, 12'd1);
      check("midreset_rgb2", rgb, 12'hFFF);

      // Randomised traffic around the sprite column
      for (int i = 0; i < 6000; i++) begin
         @(negedge clk);
         reset       = ($urandom_range(0, 799) == 0);
         frame_start = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 15) == 0)
            position = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
         pix_valid = ($urandom_range(0, 4) != 0);
         if ($urandom_range(0, 9) == 0) begin
            pix_x = 10'($urandom_range(0, 1023));
            pix_y = 10'($urandom_range(0, 1023));
         end else begin
            pix_x = 10'($urandom_range(DINO_X - 4, DINO_X + 36));
            pix_y = 10'($urandom_range(240, 410));
         end
      end
      @(negedge clk);
      reset = 1'b0; frame_start = 1'b0; pix_valid = 1'b0;
      repeat (4) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
